mvc_input_buffer: RTL

Parametrised multi-virtual-channel input buffer for a NoC router input port. It is the successor to the single-VC, depth-2 flit buffer. It stores incoming flits into one FIFO per virtual channel, selected by the flit's VC id. It tracks wormhole packet lock per VC and round-robin arbitrates the non-empty VCs onto a single output with a stable valid/ready handshake. Per-VC occupancy, lock state and a protocol error pulse are exported for the router control and debug logic.

---
 rtl/mvc_input_buffer_if.sv | 27 ++
 rtl/mvc_input_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mvc_input_buffer_if.sv
// mvc_input_buffer_if: flit handshake bundle for the multi-VC input buffer.
//   Input side  : vc_id_i / fdata_i / valid_i in, ready_o back.
//   Output side : fdata_o / vc_id_o / valid_o out, ready_i back.
//   master = upstream router/test driver, slave = the buffer.
interface mvc_input_buffer_if #(
    parameter int FLIT_WIDTH = 34,
    parameter int VC_ID_W    = 2
);
    logic [VC_ID_W-1:0]    vc_id_i;
    logic [FLIT_WIDTH-1:0] fdata_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [FLIT_WIDTH-1:0] fdata_o;
    logic [VC_ID_W-1:0]    vc_id_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (
        output vc_id_i, fdata_i, valid_i, ready_i,
        input  ready_o, fdata_o, vc_id_o, valid_o
    );

    modport slave (
        input  vc_id_i, fdata_i, valid_i, ready_i,
        output ready_o, fdata_o, vc_id_o, valid_o
    );
endinterface

// File: rtl/mvc_input_buffer.sv
// mvc_input_buffer: multi-virtual-channel NoC input buffer.
//   One FIFO per VC (selected by vc_id_i), per-VC wormhole lock tracking,
//   round-robin output arbitration with a grant that is held while the
//   downstream stalls.
// Ports:
//   clk, arst       clock / synchronous active-high reset
//   bus (slave)     input flit handshake and output flit handshake
//   ocup_o          per-VC occupancy, VC k at [k*OCUP_W +: OCUP_W]
//   locked_o        per-VC wormhole lock
//   error_o         registered one-cycle protocol error pulse

// Per-VC slot: FIFO storage, pointers and wormhole lock.
module mvc_vc_slot #(
    parameter int FLIT_WIDTH = 34,
    parameter int BUFF_DEPTH = 4,
    parameter int PKT_SZ_MSB = 29,
    parameter int PKT_SZ_LSB = 22,
    parameter int AW         = $clog2(BUFF_DEPTH),
    parameter int OCUP_W     = AW + 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  wr_en,
    input  logic [FLIT_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FLIT_WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [OCUP_W-1:0]     ocup_o,
    output logic                  locked_o
);
    logic [OCUP_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [OCUP_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                  lock_q, lock_d;
    logic [FLIT_WIDTH-1:0] mem_q [BUFF_DEPTH];
    logic [1:0]            wr_type;

    assign wr_type = wr_data[FLIT_WIDTH-1 -: 2];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lock_d   = lock_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            // HEAD with size 0 is a single-flit packet and never locks;
            // reserved and BODY leave the lock alone.
            case (wr_type)
                2'b00:   lock_d = |wr_data[PKT_SZ_MSB:PKT_SZ_LSB];
                2'b11:   lock_d = 1'b0;
                default: lock_d = lock_q;
            endcase
        end
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lock_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lock_q   <= lock_d;
        end
    end

    // Storage is intentionally not reset; emptiness is carried by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign head_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign ocup_o   = wr_ptr_q - rd_ptr_q;
    assign locked_o = lock_q;
endmodule

module mvc_input_buffer #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 3,
    parameter int BUFF_DEPTH = 4,
    parameter int PKT_SZ_MSB = 29,
    parameter int PKT_SZ_LSB = 22,
    localparam int VC_ID_W   = (N_VIRT_CHN > 2) ? $clog2(N_VIRT_CHN) : 1,
    localparam int OCUP_W    = $clog2(BUFF_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         arst,
    mvc_input_buffer_if.slave            bus,
    output logic [N_VIRT_CHN*OCUP_W-1:0] ocup_o,
    output logic [N_VIRT_CHN-1:0]        locked_o,
    output logic                         error_o
);
    logic [N_VIRT_CHN-1:0][FLIT_WIDTH-1:0] head;
    logic [N_VIRT_CHN-1:0][OCUP_W-1:0]     ocup;
    logic [N_VIRT_CHN-1:0]                 empty, full, lock, wr_en, rd_en;

    logic [1:0]         in_type;
    logic               is_head, is_body, is_tail, is_rsvd;
    logic               vc_ok, sel_full, sel_lock, ready_c, valid_c;
    logic [VC_ID_W-1:0] rr_pick, grant;

    logic [VC_ID_W-1:0] rr_last_q, rr_last_d;
    logic [VC_ID_W-1:0] grant_q, grant_d;
    logic               hold_q, hold_d;
    logic               error_q, error_d;

    assign in_type = bus.fdata_i[FLIT_WIDTH-1 -: 2];
    assign is_head = (in_type == 2'b00);
    assign is_body = (in_type == 2'b01);
    assign is_tail = (in_type == 2'b11);
    assign is_rsvd = (in_type == 2'b10);

    for (genvar k = 0; k < N_VIRT_CHN; k++) begin : g_vc
        mvc_vc_slot #(
            .FLIT_WIDTH(FLIT_WIDTH), .BUFF_DEPTH(BUFF_DEPTH),
            .PKT_SZ_MSB(PKT_SZ_MSB), .PKT_SZ_LSB(PKT_SZ_LSB)
        ) u_slot (
            .clk     (clk),
            .arst    (arst),
            .wr_en   (wr_en[k]),
            .wr_data (bus.fdata_i),
            .rd_en   (rd_en[k]),
            .head_o  (head[k]),
            .empty_o (empty[k]),
            .full_o  (full[k]),
            .ocup_o  (ocup[k]),
            .locked_o(lock[k])
        );
    end

    // Select the addressed VC's status by compare so an out-of-range
    // vc_id_i never indexes past the arrays.
    always_comb begin
        vc_ok    = int'(bus.vc_id_i) < N_VIRT_CHN;
        sel_full = 1'b0;
        sel_lock = 1'b0;
        for (int k = 0; k < N_VIRT_CHN; k++) begin
            if (bus.vc_id_i == VC_ID_W'(k)) begin
                sel_full = full[k];
                sel_lock = lock[k];
            end
        end
    end

    // During reset the stored state is about to be discarded, so only the
    // vc_id_i range gates acceptance.
    assign ready_c = vc_ok & (arst | (~sel_full & ~(sel_lock & is_head)));
    assign valid_c = (|(~empty)) & ~arst;

    // Round-robin pick: first non-empty VC after rr_last.
    always_comb begin : p_arb
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        rr_pick = '0;
        for (int i = 1; i <= N_VIRT_CHN; i++) begin
            idx = (int'(rr_last_q) + i) % N_VIRT_CHN;
            if (!found && !empty[idx]) begin
                found   = 1'b1;
                rr_pick = VC_ID_W'(idx);
            end
        end
    end

    // A stalled grant stays frozen so the presented flit cannot change.
    assign grant = hold_q ? grant_q : rr_pick;

    always_comb begin
        for (int k = 0; k < N_VIRT_CHN; k++) begin
            wr_en[k] = bus.valid_i & ready_c & ~arst & (bus.vc_id_i == VC_ID_W'(k));
            rd_en[k] = valid_c & bus.ready_i & (grant == VC_ID_W'(k));
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        grant_d   = grant;
        hold_d    = valid_c & ~bus.ready_i;
        error_d   = 1'b0;
        if (valid_c && bus.ready_i) rr_last_d = grant;
        if (bus.valid_i && !arst) begin
            if (!vc_ok) error_d = 1'b1;
            else if (((is_body | is_tail) & ~sel_lock) | is_rsvd | sel_full)
                error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            rr_last_q <= VC_ID_W'(N_VIRT_CHN - 1);
            grant_q   <= '0;
            hold_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        bus.fdata_o = '0;
        for (int k = 0; k < N_VIRT_CHN; k++) begin
            if (valid_c && grant == VC_ID_W'(k)) bus.fdata_o = head[k];
        end
    end

    assign bus.ready_o = ready_c;
    assign bus.valid_o = valid_c;
    assign bus.vc_id_o = valid_c ? grant : '0;
    assign ocup_o      = arst ? '0 : ocup;
    assign locked_o    = arst ? '0 : lock;
    assign error_o     = error_q & ~arst;
endmodule
